if_fetch_ctrl: RTL
==================

// Module: if_fetch_ctrl
// PURPOSE
//  Instruction-fetch sequencer for the 5-stage MIPS pipeline. Owns the PC and drives the combinational
//  instruction ROM address. Captures the returned word into the IF/ID register.
//  Arbitrates sequential/branch/jump/jr redirects and stalls, and inserts bubbles on flush.
// PARAMETERS
//  RESET_PC    32'h00000000  PC loaded on reset (CPU starts at 0x0, not the 0x00400000 MARS base)
//  EXC_VECTOR  32'h80000004  exception entry PC (used only with IF_EXCEPTION_EN)
//  NOP_WORD    32'h00000000  word injected into IF/ID on bubble/flush
// PORTS
//  clk            in   1   system clock, all state on rising edge
//  reset          in   1   synchronous, active-high reset
//  stall          in   1   load-use hazard from ID: hold PC and IF/ID
//  br_taken       in   1   branch resolved taken in EX (beq/bne)
//  br_target      in   32  branch target from EX
//  j_taken        in   1   j/jal decoded in ID
//  j_target       in   32  {PC+4[31:28], imm26, 2'b00} from ID
//  jr_taken       in   1   jr/jalr decoded in ID (rs already forwarded)
//  jr_target      in   32  forwarded rs value
//  imem_addr      out  32  address to instruction ROM (= pc, combinational)
//  imem_instr     in   32  ROM read data, valid same cycle
//  pc             out  32  current fetch PC
//  ifid_instr     out  32  IF/ID instruction register
//  ifid_pc_plus4  out  32  IF/ID PC+4 (jal link value, branch base)
//  ifid_valid     out  1   IF/ID holds a real instruction
//  exc_req, epc   in 1 / out 32  present only with IF_EXCEPTION_EN
// BEHAVIOUR
//  Reset
//   - pc=RESET_PC, ifid_instr=NOP_WORD, ifid_pc_plus4=0, ifid_valid=0, state=BOOT.
//  FSM states: BOOT, RUN, FLUSH.
//   - BOOT lasts exactly one cycle after reset deasserts: the fetch at RESET_PC is captured, ifid_valid=1 next, ->RUN.
//   - RUN->FLUSH on any redirect. FLUSH->RUN after one cycle.
//  Next-PC priority per cycle, highest first:
//   1. reset
//   2. exc_req (opt)
//   3. br_taken: pc<=br_target; IF/ID AND the ID instr are squashed (ifid_valid<=0, NOP)
//   4. jr_taken: pc<=jr_target
//   5. j_taken: pc<=j_target
//   6. stall: pc, IF/ID hold
//   7. default: pc<=pc+4
//  Redirect rules
//   - Redirect beats stall in the same cycle (the stalled ID instr is killed or is the jump itself).
//   - For 4 and 5, IF/ID<=NOP, valid<=0 (one bubble, no delay slot).
//   - br_taken together with j/jr_taken: the branch wins (older instruction).
//  Sequential fetch latency
//   - imem_addr=pc combinationally.
//   - imem_instr is captured in IF/ID at the next edge with ifid_pc_plus4=pc+4.
//  Arithmetic
//   - pc+4 is 32-bit modulo: 0xFFFFFFFC+4 wraps to 0. The ROM decodes only pc[9:2], so fetch aliases every 1 KB.
//   - pc[1:0] is always 2'b00. Low bits of redirect targets are forced to 0.
//  Reset mid-operation overrides stall and all redirects. Everything returns to its reset values next edge.
// CONFIGURATION
//  IF_EXCEPTION_EN defined
//   - exc_req has priority over all redirects: pc<=EXC_VECTOR, epc<=pc (faulting fetch PC), IF/ID flushed.
//   - epc resets to 0 and holds otherwise.
//  IF_EXCEPTION_EN undefined
//   - exc_req/epc ports are absent and the priority list starts at br_taken.
// STRUCTURE
//  Shared package mips_pkg
//   - RESET_PC, EXC_VECTOR, NOP_WORD, PC width, fetch-state enum {BOOT,RUN,FLUSH}.
//  Sub-module pc_next_mux
//   - combinational priority select of next PC. Reused by the simulator model.
//  IF/ID register and FSM live in the top.
// TESTING
//  Release reset at 0 -> imem_addr 0x0,0x4,0x8 on consecutive cycles; ifid_valid 0 then 1 from cycle 2.
//  stall=1 for 2 cycles at pc=0x10 -> pc holds 0x10, IF/ID unchanged; pc=0x14 the cycle after release.
//  br_taken, br_target=0x1C, pc=0x20 -> pc=0x1C next; ifid_valid=0, ifid_instr=0 for one cycle.
//  j_taken=1 and br_taken=1 same cycle (j_target=0x5C, br_target=0x30) -> pc=0x30.
//  jr_taken with stall=1, jr_target=0x60 -> pc=0x60 (redirect beats stall), one bubble.
//  IF_EXCEPTION_EN: exc_req at pc=0x48 -> pc=0x80000004, epc=0x48; reset mid-run -> pc=0, valid=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: reset/exception PCs, NOP word, fetch FSM states,
// next-PC select codes and the redirect request struct used by the fetch sequencer.
package mips_pkg;

    localparam int PC_W = 32;

    localparam logic [PC_W-1:0] RESET_PC_DEF   = 32'h0000_0000;
    localparam logic [PC_W-1:0] EXC_VECTOR_DEF = 32'h8000_0004;
    localparam logic [31:0]     NOP_WORD_DEF   = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } fetch_state_e;

    typedef enum logic [2:0] {
        SEL_SEQ  = 3'd0,
        SEL_HOLD = 3'd1,
        SEL_J    = 3'd2,
        SEL_JR   = 3'd3,
        SEL_BR   = 3'd4,
        SEL_EXC  = 3'd5
    } pc_sel_e;

    typedef struct packed {
        logic            taken;
        logic [PC_W-1:0] target;
    } redirect_t;

    // Fetch addresses are word aligned; redirect targets get their low bits cleared.
    function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] a);
        return a & ~{{(PC_W-2){1'b0}}, 2'b11};
    endfunction

    function automatic logic is_redirect(input pc_sel_e s);
        return (s == SEL_BR) || (s == SEL_JR) || (s == SEL_J) || (s == SEL_EXC);
    endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Combinational next-PC priority select: exc (IF_EXCEPTION_EN) > br > jr > j > stall > pc+4.
// Shared with the simulator model, so it carries no state.
module pc_next_mux
    import mips_pkg::*;
#(
`ifdef IF_EXCEPTION_EN
    parameter logic [PC_W-1:0] EXC_VECTOR = EXC_VECTOR_DEF
`endif
) (
    input  logic [PC_W-1:0] pc,
    input  logic            stall,
    input  redirect_t       br,
    input  redirect_t       jr,
    input  redirect_t       j,
`ifdef IF_EXCEPTION_EN
    input  logic            exc_req,
`endif
    output logic [PC_W-1:0] pc_next,
    output pc_sel_e         sel
);

    logic [PC_W-1:0] pc_plus4;

    // Modulo-2^32 increment; 0xFFFFFFFC wraps to 0.
    assign pc_plus4 = pc + 32'd4;

    always_comb begin
        sel     = SEL_SEQ;
        pc_next = pc_plus4;
`ifdef IF_EXCEPTION_EN
        if (exc_req) begin
            sel     = SEL_EXC;
            pc_next = word_align(EXC_VECTOR);
        end else
`endif
        if (br.taken) begin
            sel     = SEL_BR;
            pc_next = word_align(br.target);
        end else if (jr.taken) begin
            sel     = SEL_JR;
            pc_next = word_align(jr.target);
        end else if (j.taken) begin
            sel     = SEL_J;
            pc_next = word_align(j.target);
        end else if (stall) begin
            sel     = SEL_HOLD;
            pc_next = pc;
        end
    end

endmodule

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives the ROM address, fills IF/ID and
// inserts bubbles on redirects. Optional exception entry under IF_EXCEPTION_EN.
module if_fetch_ctrl
    import mips_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC   = RESET_PC_DEF,
`ifdef IF_EXCEPTION_EN
    parameter logic [PC_W-1:0] EXC_VECTOR = EXC_VECTOR_DEF,
`endif
    parameter logic [31:0]     NOP_WORD   = NOP_WORD_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            br_taken,
    input  logic [PC_W-1:0] br_target,
    input  logic            j_taken,
    input  logic [PC_W-1:0] j_target,
    input  logic            jr_taken,
    input  logic [PC_W-1:0] jr_target,
    output logic [PC_W-1:0] imem_addr,
    input  logic [31:0]     imem_instr,
    output logic [PC_W-1:0] pc,
    output logic [31:0]     ifid_instr,
    output logic [PC_W-1:0] ifid_pc_plus4,
`ifdef IF_EXCEPTION_EN
    input  logic            exc_req,
    output logic [PC_W-1:0] epc,
`endif
    output logic            ifid_valid
);

    fetch_state_e    state_q, state_d;
    pc_sel_e         sel;
    logic [PC_W-1:0] pc_next;
    logic            boot;
    redirect_t       br_req, jr_req, j_req;
    logic            stall_req;

    assign imem_addr = pc;
    assign boot      = (state_q == BOOT);

    // Downstream stages are empty during BOOT, so their stall/redirect requests are ignored.
    always_comb begin
        br_req.taken  = br_taken && !boot;
        br_req.target = br_target;
        jr_req.taken  = jr_taken && !boot;
        jr_req.target = jr_target;
        j_req.taken   = j_taken && !boot;
        j_req.target  = j_target;
        stall_req     = stall && !boot;
    end

    pc_next_mux
`ifdef IF_EXCEPTION_EN
        #(.EXC_VECTOR(EXC_VECTOR))
`endif
    u_pc_next_mux (
        .pc      (pc),
        .stall   (stall_req),
        .br      (br_req),
        .jr      (jr_req),
        .j       (j_req),
`ifdef IF_EXCEPTION_EN
        .exc_req (exc_req),
`endif
        .pc_next (pc_next),
        .sel     (sel)
    );

    always_comb begin
        state_d = state_q;
        if (is_redirect(sel)) begin
            state_d = FLUSH;
        end else begin
            case (state_q)
                BOOT:    state_d = RUN;
                FLUSH:   state_d = RUN;
                RUN:     state_d = RUN;
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= BOOT;
            pc            <= word_align(RESET_PC);
            ifid_instr    <= NOP_WORD;
            ifid_pc_plus4 <= '0;
            ifid_valid    <= 1'b0;
        end else begin
            state_q <= state_d;
            pc      <= pc_next;
            case (sel)
                SEL_HOLD: begin
                    ifid_instr    <= ifid_instr;
                    ifid_pc_plus4 <= ifid_pc_plus4;
                    ifid_valid    <= ifid_valid;
                end
                SEL_SEQ: begin
                    ifid_instr    <= imem_instr;
                    ifid_pc_plus4 <= pc + 32'd4;
                    ifid_valid    <= 1'b1;
                end
                // Any redirect squashes the word fetched this cycle: one bubble, no delay slot.
                default: begin
                    ifid_instr    <= NOP_WORD;
                    ifid_pc_plus4 <= pc + 32'd4;
                    ifid_valid    <= 1'b0;
                end
            endcase
        end
    end

`ifdef IF_EXCEPTION_EN
    always_ff @(posedge clk) begin
        if (reset)
            epc <= '0;
        else if (sel == SEL_EXC)
            epc <= pc;
    end
`endif

endmodule
